// File: rtl/conv_engine_arbiter_if.sv
// Bus bundle between the per-requester controllers, the arbiter and the
// shared conv_engine.
//   Requester side : req_valid / req_ready / req_pixel_data (NUM_REQ*256b rows),
//                    rsp_valid / rsp_error / rsp_result (30 x 18b signed).
//   Engine side    : eng_start / eng_pixel_row_data / eng_done / eng_result.
// slave  : the arbiter's view (drives ready, responses and the engine launch).
// master : the environment's view (requesters plus engine).
interface conv_engine_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*256-1:0] req_pixel_data;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic                   rsp_error;
  logic [539:0]           rsp_result;
  logic                   eng_start;
  logic [255:0]           eng_pixel_row_data;
  logic                   eng_done;
  logic [539:0]           eng_result;

  modport slave (
    input  req_valid, req_pixel_data, eng_done, eng_result,
    output req_ready, rsp_valid, rsp_error, rsp_result,
           eng_start, eng_pixel_row_data
  );

  modport master (
    output req_valid, req_pixel_data, eng_done, eng_result,
    input  req_ready, rsp_valid, rsp_error, rsp_result,
           eng_start, eng_pixel_row_data
  );
endinterface

// File: rtl/conv_engine_arbiter.sv
// conv_engine_arbiter: shares one conv_engine between NUM_REQ requesters.
// Requests are granted round-robin; the winner's 32-pixel row is registered
// and launched with a one-cycle eng_start, eng_done is awaited under a
// watchdog of TIMEOUT_CYCLES WAIT cycles, and the 30 results (or zeros plus
// rsp_error on timeout) are returned with a one-cycle rsp_valid pulse.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : requester/engine bundle (slave modport)
//   busy       : high whenever the FSM is not IDLE
//   grant_id   : current owner, valid while busy
//   jobs_done  : successful responses, saturating at 16'hFFFF
module conv_engine_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  conv_engine_arbiter_if.slave bus,
  output logic                busy,
  output logic [GW-1:0]       grant_id,
  output logic [15:0]         jobs_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESPOND
  } state_t;

  state_t        state, state_d;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] grant_q;
  logic [CW-1:0] wd_cnt;
  logic [255:0]  row_q;
  logic [539:0]  result_q;
  logic          err_q;
  logic [15:0]   jobs_q;

  logic          win_found;
  logic [GW-1:0] win_idx;
  logic          timeout_hit;

  // Round-robin search: first asserted req_valid at or above rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = k + 32'(rr_ptr);
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && bus.req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = GW'(idx);
      end
    end
  end

  assign timeout_hit = (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:    if (win_found) state_d = S_LAUNCH;
      S_LAUNCH:  state_d = S_WAIT;
      S_WAIT:    if (bus.eng_done || timeout_hit) state_d = S_RESPOND;
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath registers. eng_done is only looked at in WAIT, so a late done
  // from an aborted job (e.g. after reset) cannot disturb rsp_result.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      grant_q  <= '0;
      wd_cnt   <= '0;
      row_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      jobs_q   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (win_found) begin
            row_q   <= bus.req_pixel_data[win_idx*256 +: 256];
            grant_q <= win_idx;
          end
        end
        S_LAUNCH: wd_cnt <= '0;
        S_WAIT: begin
          // done has priority over a timeout in the same cycle
          if (bus.eng_done) begin
            result_q <= bus.eng_result;
            err_q    <= 1'b0;
          end else if (timeout_hit) begin
            result_q <= '0;
            err_q    <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_RESPOND: begin
          rr_ptr <= (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          if (!err_q && jobs_q != 16'hFFFF) jobs_q <= jobs_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; req_ready is forced low while rst is held.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    if (state == S_IDLE && !rst && win_found) bus.req_ready[win_idx] = 1'b1;
    if (state == S_RESPOND) bus.rsp_valid[grant_q] = 1'b1;
  end

  assign bus.rsp_error          = (state == S_RESPOND) && err_q;
  assign bus.rsp_result         = result_q;
  assign bus.eng_start          = (state == S_LAUNCH);
  assign bus.eng_pixel_row_data = row_q;
  assign busy                   = (state != S_IDLE);
  assign grant_id               = grant_q;
  assign jobs_done              = jobs_q;

endmodule

// File: tb/tb_conv_engine_arbiter.sv
// Directed bench for conv_engine_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_conv_engine_arbiter;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned TMO     = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [0:0]  grant_id;
  logic [15:0] jobs_done;
  int unsigned cyc = 0;
  int          vectors = 0;
  int          errors = 0;
  logic [255:0] row0, row1;

  conv_engine_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  conv_engine_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .busy(busy), .grant_id(grant_id), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  // result i = base + i, as 18-bit two's complement
  function automatic logic [539:0] make_result(input int base);
    logic [539:0] r;
    r = '0;
    for (int i = 0; i < 30; i++) r[i*18 +: 18] = 18'(base + i);
    return r;
  endfunction

  // Runs one job with the caller's req_valid; eng_done is pulsed delay cycles
  // after eng_start (delay < 0: never). Returns observations only.
  task automatic run_job(input int delay, input logic [539:0] res, output bit ok,
                         output int unsigned t0, output logic ls, output int xs,
                         output logic [0:0] gid, output logic [255:0] row,
                         output logic [1:0] rv, output logic re,
                         output logic [539:0] rr, output int lat);
    ok = 0; t0 = 0; ls = 0; xs = 0; gid = '0; row = '0; rv = '0; re = 0; rr = '0; lat = -1;
    #1;
    for (int w = 0; w < 20 && (bus.req_ready & bus.req_valid) == '0; w++) tick();
    if ((bus.req_ready & bus.req_valid) == '0) return;
    t0 = cyc;
    tick();
    ls = bus.eng_start; gid = grant_id; row = bus.eng_pixel_row_data;
    for (int k = 1; k <= 40; k++) begin
      bus.eng_done   = (k == delay + 1);
      bus.eng_result = (k == delay + 1) ? res : '1;
      tick();
      bus.eng_done = 0;
      if (bus.rsp_valid != '0) begin
        rv = bus.rsp_valid; re = bus.rsp_error; rr = bus.rsp_result;
        lat = int'(cyc - t0); ok = 1;
        break;
      end
      xs += int'(bus.eng_start);
    end
    if (ok) tick();
  endtask

  task automatic test_reset();
    rst = 1; bus.req_valid = 2'b11; bus.eng_done = 0; bus.eng_result = '0;
    repeat (3) tick();
    vectors++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b expected 00", bus.req_ready); end
    vectors++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 00", bus.rsp_valid); end
    vectors++; if (bus.eng_start !== 1'b0) begin errors++; $display("FAIL rst_eng_start: got %b expected 0", bus.eng_start); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    vectors++; if (jobs_done !== 16'd0) begin errors++; $display("FAIL rst_jobs: got %0d expected 0", jobs_done); end
    vectors++; if (bus.rsp_result !== 540'd0) begin errors++; $display("FAIL rst_result: got %h expected 0", bus.rsp_result); end
    vectors++; if (bus.eng_pixel_row_data !== 256'd0) begin errors++; $display("FAIL rst_row: got %h expected 0", bus.eng_pixel_row_data); end
    vectors++; if (grant_id !== 1'b0) begin errors++; $display("FAIL rst_grant: got %0d expected 0", grant_id); end
    bus.req_valid = 2'b00; rst = 0;
    tick();
  endtask

  task automatic test_contention();
    bit ok; int unsigned t0; logic ls; int xs; logic [0:0] gid; logic [255:0] row;
    logic [1:0] rv; logic re; logic [539:0] rr, res; int lat;
    bus.req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      res = make_result(100 * j + 1);
      run_job(4, res, ok, t0, ls, xs, gid, row, rv, re, rr, lat);
      vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL cont_complete job%0d: got %0d expected 1", j, ok); end
      vectors++; if (gid !== 1'(j % 2)) begin errors++; $display("FAIL cont_grant job%0d: got %0d expected %0d", j, gid, j % 2); end
      vectors++; if (rv !== ((j % 2) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cont_rsp_valid job%0d: got %b", j, rv); end
      vectors++; if (row !== ((j % 2) ? row1 : row0)) begin errors++; $display("FAIL cont_row job%0d: got %h", j, row); end
      vectors++; if (rr !== res || re !== 1'b0) begin errors++; $display("FAIL cont_result job%0d: got %h err %b expected %h err 0", j, rr, re, res); end
      vectors++; if (lat !== 6) begin errors++; $display("FAIL cont_latency job%0d: got %0d expected 6", j, lat); end
    end
    bus.req_valid = 2'b00;
    vectors++; if (jobs_done !== 16'd4) begin errors++; $display("FAIL cont_jobs: got %0d expected 4", jobs_done); end
  endtask

  task automatic test_single();
    bit ok; int unsigned t0; logic ls; int xs; logic [0:0] gid; logic [255:0] row;
    logic [1:0] rv; logic re; logic [539:0] rr, res; int lat;
    res = make_result(-15);
    bus.req_valid = 2'b01;
    run_job(5, res, ok, t0, ls, xs, gid, row, rv, re, rr, lat);
    bus.req_valid = 2'b00;
    vectors++; if (ls !== 1'b1) begin errors++; $display("FAIL single_start_T1: got %b expected 1", ls); end
    vectors++; if (xs !== 0) begin errors++; $display("FAIL single_extra_starts: got %0d expected 0", xs); end
    vectors++; if (rv !== 2'b01 || re !== 1'b0) begin errors++; $display("FAIL single_rsp: got valid %b err %b expected 01 0", rv, re); end
    vectors++; if (rr[17:0] !== 18'h3FFF1) begin errors++; $display("FAIL single_res0: got %h expected 3fff1", rr[17:0]); end
    vectors++; if (rr[29*18 +: 18] !== 18'd14) begin errors++; $display("FAIL single_res29: got %h expected 0000e", rr[29*18 +: 18]); end
    vectors++; if (lat !== 7) begin errors++; $display("FAIL single_latency: got %0d expected 7", lat); end
    vectors++; if (row !== row0) begin errors++; $display("FAIL single_row: got %h expected %h", row, row0); end
    vectors++; if (jobs_done !== 16'd5) begin errors++; $display("FAIL single_jobs: got %0d expected 5", jobs_done); end
  endtask

  task automatic test_timeout();
    bit ok; int unsigned t0; logic ls; int xs; logic [0:0] gid; logic [255:0] row;
    logic [1:0] rv; logic re; logic [539:0] rr; int lat;
    bus.req_valid = 2'b01;
    run_job(-1, '0, ok, t0, ls, xs, gid, row, rv, re, rr, lat);
    bus.req_valid = 2'b00;
    vectors++; if (rv !== 2'b01 || re !== 1'b1) begin errors++; $display("FAIL tmo_rsp: got valid %b err %b expected 01 1", rv, re); end
    vectors++; if (rr !== 540'd0) begin errors++; $display("FAIL tmo_result: got %h expected 0", rr); end
    vectors++; if (lat !== 10) begin errors++; $display("FAIL tmo_latency: got %0d expected 10", lat); end
    vectors++; if (jobs_done !== 16'd5) begin errors++; $display("FAIL tmo_jobs: got %0d expected 5", jobs_done); end
  endtask

  task automatic test_tie();
    bit ok; int unsigned t0; logic ls; int xs; logic [0:0] gid; logic [255:0] row;
    logic [1:0] rv; logic re; logic [539:0] rr, res; int lat;
    res = make_result(-200);
    bus.req_valid = 2'b01;
    run_job(8, res, ok, t0, ls, xs, gid, row, rv, re, rr, lat);
    bus.req_valid = 2'b00;
    vectors++; if (rv !== 2'b01 || re !== 1'b0) begin errors++; $display("FAIL tie_rsp: got valid %b err %b expected 01 0", rv, re); end
    vectors++; if (rr !== res) begin errors++; $display("FAIL tie_result: got %h expected %h", rr, res); end
    vectors++; if (lat !== 10) begin errors++; $display("FAIL tie_latency: got %0d expected 10", lat); end
    vectors++; if (jobs_done !== 16'd6) begin errors++; $display("FAIL tie_jobs: got %0d expected 6", jobs_done); end
  endtask

  task automatic test_stray_done();
    bus.eng_done = 1; bus.eng_result = make_result(999);
    tick();
    bus.eng_done = 0;
    vectors++; if (bus.rsp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL stray_idle1: got valid %b busy %b expected 00 0", bus.rsp_valid, busy); end
    tick();
    vectors++; if (bus.rsp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL stray_idle2: got valid %b busy %b expected 00 0", bus.rsp_valid, busy); end
    vectors++; if (bus.rsp_result !== make_result(-200)) begin errors++; $display("FAIL stray_result_held: got %h", bus.rsp_result); end
  endtask

  task automatic test_reset_in_wait();
    bus.req_valid = 2'b10;
    #1;
    for (int w = 0; w < 20 && (bus.req_ready & bus.req_valid) == '0; w++) tick();
    vectors++; if ((bus.req_ready & bus.req_valid) !== 2'b10) begin errors++; $display("FAIL rw_accept: got ready %b expected 10", bus.req_ready); end
    repeat (3) tick();
    vectors++; if (busy !== 1'b1 || grant_id !== 1'b1) begin errors++; $display("FAIL rw_in_wait: got busy %b grant %0d expected 1 1", busy, grant_id); end
    rst = 1;
    tick();
    vectors++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rw_ready_in_rst: got %b expected 00", bus.req_ready); end
    rst = 0; bus.req_valid = 2'b00;
    bus.eng_done = 1; bus.eng_result = make_result(7);
    tick();
    bus.eng_done = 0;
    vectors++; if (bus.rsp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rw_late_done: got valid %b busy %b expected 00 0", bus.rsp_valid, busy); end
    tick();
    vectors++; if (bus.rsp_valid !== 2'b00 || bus.rsp_error !== 1'b0 || bus.eng_start !== 1'b0) begin errors++; $display("FAIL rw_outputs: got valid %b err %b start %b expected 00 0 0", bus.rsp_valid, bus.rsp_error, bus.eng_start); end
    vectors++; if (bus.rsp_result !== 540'd0) begin errors++; $display("FAIL rw_result: got %h expected 0", bus.rsp_result); end
    vectors++; if (bus.eng_pixel_row_data !== 256'd0 || grant_id !== 1'b0 || jobs_done !== 16'd0) begin errors++; $display("FAIL rw_regs: got row %h grant %0d jobs %0d expected 0 0 0", bus.eng_pixel_row_data, grant_id, jobs_done); end
    bus.req_valid = 2'b11;
    #1;
    vectors++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rw_rr_reset: got %b expected 01", bus.req_ready); end
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok; int unsigned t0; logic ls; int xs; logic [0:0] gid; logic [255:0] row;
    logic [1:0] rv; logic re; logic [539:0] rr; int lat;
    int unsigned ts [3];
    bus.req_valid = 2'b10;
    for (int j = 0; j < 3; j++) begin
      run_job(1, make_result(50 * j), ok, t0, ls, xs, gid, row, rv, re, rr, lat);
      ts[j] = t0;
      vectors++; if (ok !== 1'b1 || gid !== 1'b1 || rv !== 2'b10) begin errors++; $display("FAIL b2b_job%0d: got ok %0d grant %0d valid %b expected 1 1 10", j, ok, gid, rv); end
      vectors++; if (lat !== 3) begin errors++; $display("FAIL b2b_latency job%0d: got %0d expected 3", j, lat); end
    end
    bus.req_valid = 2'b00;
    vectors++; if (ts[1] - ts[0] !== 4) begin errors++; $display("FAIL b2b_spacing01: got %0d expected 4", ts[1] - ts[0]); end
    vectors++; if (ts[2] - ts[1] !== 4) begin errors++; $display("FAIL b2b_spacing12: got %0d expected 4", ts[2] - ts[1]); end
    vectors++; if (jobs_done !== 16'd3) begin errors++; $display("FAIL b2b_jobs: got %0d expected 3", jobs_done); end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      row0[k*8 +: 8] = 8'(k);
      row1[k*8 +: 8] = 8'(8'h80 + k);
    end
    bus.req_pixel_data = {row1, row0};
    bus.req_valid      = '0;
    bus.eng_done       = 0;
    bus.eng_result     = '0;
    test_reset();
    test_contention();
    test_single();
    test_timeout();
    test_tie();
    test_stray_done();
    test_reset_in_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/conv_engine_arbiter.md
# conv_engine_arbiter

Shares one `conv_engine` instance between `NUM_REQ` requesters (lane-detect controllers, calibration path, test injector). Each request carries a 32-pixel row. The arbiter grants requesters round-robin, loads the row into the engine, pulses `start`, and waits for `done` under a watchdog. It then returns the 30 convolution results to the owning requester with a one-cycle response pulse. It sits between the per-requester controllers and the single engine.

## Interface
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 1024: number of WAIT cycles without `eng_done` before an error response; must be ≥ 2.
- `clk` in 1: clock. Single clock domain; reset is synchronous and active-high.
- `rst` in 1: synchronous active-high reset.
- `req_valid` in NUM_REQ: request pending, one bit per requester.
- `req_ready` out NUM_REQ: one-hot accept; a transfer occurs when `req_valid[i] && req_ready[i]`.
- `req_pixel_data` in NUM_REQ*256: row for requester i at `[i*256 +: 256]`; pixel k of that row at bits `[k*8 +: 8]`.
- `rsp_valid` out NUM_REQ: one-hot, one-cycle response pulse to the owning requester.
- `rsp_error` out 1: qualifies `rsp_valid`; 1 means watchdog timeout.
- `rsp_result` out 540: 30 signed 18-bit results, result i at `[i*18 +: 18]`; held until the next response.
- `eng_start` out 1: one-cycle start pulse to the engine.
- `eng_pixel_row_data` out 256: registered row driven to the engine; held stable from LAUNCH until the next accept.
- `eng_done` in 1: engine completion pulse.
- `eng_result` in 540: engine results, valid in the cycle `eng_done` is high.
- `busy` out 1: high in any state other than IDLE.
- `grant_id` out $clog2(NUM_REQ) (minimum 1 bit): index of the current owner; valid while `busy`.
- `jobs_done` out 16: count of successful responses, saturating at 16'hFFFF.

## Operation
- States: IDLE, LAUNCH, WAIT, RESPOND.
- **IDLE**
  - `req_ready` is combinational and high only in IDLE.
  - It selects the first `req_valid` bit found by searching upward from `rr_ptr`, wrapping at NUM_REQ.
  - On transfer: latch the winner's row into `eng_pixel_row_data`, set `grant_id` to the winner, go to LAUNCH.
- **LAUNCH**
  - `eng_start` = 1 for exactly this cycle.
  - Clear the watchdog counter, go to WAIT.
- **WAIT**
  - If `eng_done`: register `eng_result` into `rsp_result`, clear the error flag, go to RESPOND.
  - Otherwise, if the counter == TIMEOUT_CYCLES-1: set `rsp_result` to 0 and the error flag to 1, go to RESPOND.
  - Otherwise: increment the counter.
  - If `eng_done` and the timeout condition occur in the same cycle, `eng_done` wins and the response is normal.
- **RESPOND**
  - `rsp_valid[grant_id]` = 1 and `rsp_error` = error flag, for one cycle.
  - Set `rr_ptr` to `(grant_id+1) mod NUM_REQ`.
  - Increment `jobs_done` (saturating) if there was no error.
  - Go to IDLE.
- `eng_done` outside WAIT is ignored: it does not change state or `rsp_result`.
- A requester whose `req_valid` drops before it is granted loses nothing; there is no queueing inside the arbiter.
- `req_pixel_data` need only be stable in the transfer cycle.
- Reset in any state:
  - Go to IDLE.
  - `rr_ptr`, `grant_id` and the watchdog counter become 0.
  - All outputs take their reset values.
  - An in-flight engine `done` arriving after reset is ignored, per the rule above.

## Timing
- Reset values:
  - `req_ready` = 0 during reset; it is combinational from IDLE afterwards.
  - `rsp_valid`, `rsp_error`, `eng_start`, `busy` = 0.
  - `rsp_result`, `eng_pixel_row_data`, `grant_id`, `jobs_done` = 0.
- Transfer at cycle T:
  - `eng_start` is high in T+1 (LAUNCH).
  - WAIT begins at T+2.
- `eng_done` seen at cycle D ≥ T+2:
  - `rsp_valid` and the new `rsp_result` are visible at D+1.
  - IDLE at D+2, and a new transfer is possible at D+2.
- Minimum transfer-to-transfer spacing is 4 cycles when the engine answers in its first WAIT cycle.
- Timeout: with no `eng_done`, `rsp_valid` with `rsp_error` = 1 appears at T+2+TIMEOUT_CYCLES.
- `busy` is high from T+1 through D+1 inclusive.

## Test plan
- **Single request.** NUM_REQ=2. Only `req_valid[0]`; engine returns `done` 5 cycles after `start` with result i = i-15.
  - Required: `eng_start` one pulse at T+1.
  - `rsp_valid` = 2'b01 with `rsp_error` = 0, `rsp_result[0]` = -15 and `rsp_result[29]` = 14.
  - `jobs_done` = 1.
- **Contention.** Both `req_valid` held high for 4 jobs.
  - Required: grants alternate 0,1,0,1.
  - Each `rsp_valid` matches that job's `grant_id`.
  - Each `eng_pixel_row_data` equals the respective requester's row.
- **Timeout.** TIMEOUT_CYCLES=8, engine never answers.
  - Required: `rsp_valid[0]` with `rsp_error` = 1 and `rsp_result` = 0, exactly 10 cycles after the transfer.
  - `jobs_done` unchanged.
- **Done/timeout tie.** TIMEOUT_CYCLES=8, `eng_done` in the 8th WAIT cycle.
  - Required: `rsp_error` = 0 and the engine result is returned.
- **Stray done and reset.**
  - `eng_done` pulsed in IDLE: no response, `rsp_result` unchanged.
  - `rst` asserted in WAIT, then the old `done` arrives: arbiter in IDLE, no `rsp_valid`, all outputs at reset values.
- **Back-to-back, single requester.** `req_valid[1]` held for 3 jobs with `done` 1 cycle after `start`.
  - Required: transfers spaced exactly 4 cycles apart.
  - `jobs_done` = 3.
